i2c_slave_port: RTL

Memory-mapped I2C target (slave) peripheral that sits on the bus side opposite the `I2C_master`. It consumes the START/address/data/STOP sequences the master produces, stores up to 4 written bytes, and returns up to 4 CPU-loaded bytes on reads. The CPU accesses it through the same byte-addressed peripheral bus as the other peripherals. It is used as an on-chip loopback target and as a bus endpoint on the shared SDA/SCL pair.

---
 rtl/i2c_slave_port.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_port.sv
// i2c_slave_port: memory-mapped I2C target, 4-byte RX/TX buffers, CPU byte bus.
// Optional I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample stability filter on SCL/SDA.
module i2c_slave_port #(
    parameter logic [6:0] SLV_ADDR = 7'h50
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        write_i,
    input  logic [3:0]  data_be_i,
    input  logic [4:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic        scl_i,
    inout  wire         sda_io
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ADDR  = 3'd1;
    localparam logic [2:0] AACK  = 3'd2;
    localparam logic [2:0] WDATA = 3'd3;
    localparam logic [2:0] WACK  = 3'd4;
    localparam logic [2:0] RDATA = 3'd5;
    localparam logic [2:0] RACK  = 3'd6;
    localparam logic [2:0] SKIP  = 3'd7;

    logic [2:0]  state, cnt, idx, idx_n, rx_cnt;
    logic [7:0]  sh, nxt, w1c, sta;
    logic [31:0] rdr, tdr;
    logic        en, busy, rx_done, tx_done, ovf, rw, ack, full, wr_act, oe;
    logic [1:0]  scl_ff, sda_ff;
    logic        scl_s, sda_s, scl_p, sda_p;
    logic [5:0]  la [4];
    logic [3:0]  we;

    assign sda_io = oe ? 1'b0 : 1'bz;

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] scl_h, sda_h;
    logic       scl_f, sda_f;
    assign scl_s = (scl_ff[1] == scl_h[0] && scl_h[0] == scl_h[1]) ? scl_ff[1] : scl_f;
    assign sda_s = (sda_ff[1] == sda_h[0] && sda_h[0] == sda_h[1]) ? sda_ff[1] : sda_f;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_h <= '0;
            sda_h <= '0;
            scl_f <= 1'b0;
            sda_f <= 1'b0;
        end else begin
            scl_h <= {scl_h[0], scl_ff[1]};
            sda_h <= {sda_h[0], sda_ff[1]};
            scl_f <= scl_s;
            sda_f <= sda_s;
        end
    end
`else
    assign scl_s = scl_ff[1];
    assign sda_s = sda_ff[1];
`endif

    wire scl_rise = scl_s & ~scl_p;
    wire scl_fall = ~scl_s & scl_p;
    wire start    = scl_s & scl_p & sda_p & ~sda_s;
    wire stop     = scl_s & scl_p & ~sda_p & sda_s;

    assign sta   = {1'b0, ovf, rx_cnt, busy, tx_done, rx_done};
    assign idx_n = (idx == 3'd4) ? 3'd4 : idx + 3'd1;
    assign nxt   = idx_n[2] ? 8'hFF : tdr[{idx_n[1:0], 3'b000} +: 8];

    always_comb begin
        rdata_o = '0;
        w1c     = '0;
        we      = '0;
        for (int i = 0; i < 4; i++) begin
            la[i] = {1'b0, addr_i} + 6'(i);
            we[i] = write_i & data_be_i[i] & (la[i] <= 6'd12);
            if (data_be_i[i])
                rdata_o[8*i +: 8] = (la[i] == 6'd0)    ? sta :
                                    (la[i][5:2] == 4'd1) ? rdr[{la[i][1:0], 3'b000} +: 8] :
                                    (la[i][5:2] == 4'd2) ? tdr[{la[i][1:0], 3'b000} +: 8] :
                                    (la[i] == 6'd12)   ? {7'b0, en} : 8'h00;
            if (we[i] && la[i] == 6'd0)
                w1c = wdata_i[8*i +: 8];
        end
    end

    // Hardware sets are assigned after the W1C clears so a same-cycle set wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_ff <= '0;
            sda_ff <= '0;
            scl_p <= 1'b0;
            sda_p <= 1'b0;
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            rx_cnt <= '0;
            sh <= '0;
            rdr <= '0;
            tdr <= '0;
            en <= 1'b0;
            busy <= 1'b0;
            rx_done <= 1'b0;
            tx_done <= 1'b0;
            ovf <= 1'b0;
            rw <= 1'b0;
            ack <= 1'b0;
            full <= 1'b0;
            wr_act <= 1'b0;
            oe <= 1'b0;
        end else begin
            scl_ff <= {scl_ff[0], scl_i};
            sda_ff <= {sda_ff[0], sda_io};
            scl_p <= scl_s;
            sda_p <= sda_s;
            for (int i = 0; i < 4; i++)
                if (we[i]) begin
                    if (la[i][5:2] == 4'd2) tdr[{la[i][1:0], 3'b000} +: 8] <= wdata_i[8*i +: 8];
                    if (la[i] == 6'd12) en <= wdata_i[8*i];
                end
            rx_done <= rx_done & ~w1c[0];
            tx_done <= tx_done & ~w1c[1];
            ovf <= ovf & ~w1c[6];
            if (state != IDLE && (start || stop)) begin
                if (wr_act && rx_cnt != 3'd0) rx_done <= 1'b1;
                wr_act <= 1'b0;
                oe <= 1'b0;
                full <= 1'b0;
                cnt <= 3'd7;
                state <= (start && en) ? ADDR : IDLE;
                busy <= start && en;
            end else if (state == IDLE) begin
                if (start && en) begin
                    state <= ADDR;
                    cnt <= 3'd7;
                    full <= 1'b0;
                    busy <= 1'b1;
                end
            end else if (!en) begin
                state <= SKIP;
                oe <= 1'b0;
            end else begin
                case (state)
                    ADDR, WDATA: begin
                        if (scl_rise) begin
                            sh <= {sh[6:0], sda_s};
                            full <= (cnt == 3'd0);
                            cnt <= cnt - 3'd1;
                        end else if (scl_fall && full) begin
                            full <= 1'b0;
                            if (state == ADDR) begin
                                state <= (sh[7:1] == SLV_ADDR) ? AACK : SKIP;
                                oe <= (sh[7:1] == SLV_ADDR);
                                rw <= sh[0];
                            end else begin
                                state <= WACK;
                                if (!rx_cnt[2]) begin
                                    rdr[{rx_cnt[1:0], 3'b000} +: 8] <= sh;
                                    rx_cnt <= rx_cnt + 3'd1;
                                    oe <= 1'b1;
                                end else
                                    ovf <= 1'b1;
                            end
                        end
                    end
                    AACK: if (scl_fall) begin
                        cnt <= 3'd7;
                        if (rw) begin
                            idx <= '0;
                            sh <= tdr[7:0];
                            oe <= ~tdr[7];
                            state <= RDATA;
                        end else begin
                            rx_cnt <= '0;
                            wr_act <= 1'b1;
                            oe <= 1'b0;
                            state <= WDATA;
                        end
                    end
                    WACK: if (scl_fall) begin
                        oe <= 1'b0;
                        state <= WDATA;
                    end
                    RDATA: if (scl_fall) begin
                        if (cnt == 3'd0) begin
                            oe <= 1'b0;
                            state <= RACK;
                        end else begin
                            sh <= {sh[6:0], 1'b0};
                            oe <= ~sh[6];
                            cnt <= cnt - 3'd1;
                        end
                    end
                    RACK: begin
                        if (scl_rise)
                            ack <= sda_s;
                        else if (scl_fall) begin
                            if (!ack) begin
                                idx <= idx_n;
                                sh <= nxt;
                                oe <= ~nxt[7];
                                cnt <= 3'd7;
                                state <= RDATA;
                            end else begin
                                tx_done <= 1'b1;
                                state <= SKIP;
                            end
                        end
                    end
                    SKIP: oe <= 1'b0;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
